// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl: turns dual-issue decode-stage jumps into fetch redirects,
// honouring the MIPS branch delay slot, and arbitrates them against exception/eret
// and EX branch-mispredict redirects (exception > mispredict > decode jump).
// A redirect is held on redir_valid/redir_pc until fetch accepts it.
// Optional feature macro: REDIR_PERF_CNT_EN builds an accepted-redirect counter;
// without it redir_cnt is tied to zero.
module jump_redirect_ctrl #(
    parameter int unsigned         PC_W     = 32,
    parameter logic [PC_W-1:0]     RESET_PC = PC_W'(32'hBFC0_0000)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            stallD,
    input  logic            validD1,
    input  logic            validD2,
    input  logic            jump1D,
    input  logic            jump2D,
    input  logic [PC_W-1:0] pc_jump1D,
    input  logic [PC_W-1:0] pc_jump2D,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_pc,
    input  logic            br_mis_valid,
    input  logic [PC_W-1:0] br_mis_pc,
    input  logic            redir_ready,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_pc,
    output logic            flush_fetch,
    output logic            kill_slot2D,
    output logic            killD,
    output logic            ds_pending,
    output logic [31:0]     redir_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitDs,
        StRedir
    } state_t;

    state_t          state_q;
    logic            redir_valid_q;
    logic [PC_W-1:0] redir_pc_q;
    logic            flush_q;
    // Target of a slot2 jump, parked until its delay slot (next bundle's slot1) issues.
    logic [PC_W-1:0] ds_pc_q;

    logic            fire;
    logic            ext_req;
    logic [PC_W-1:0] ext_pc;

    // Decode bundle issue and external redirect arbitration (exception beats mispredict).
    always_comb begin
        fire    = validD1 & ~stallD;
        ext_req = exc_valid | br_mis_valid;
        ext_pc  = exc_valid ? exc_pc : br_mis_pc;
    end

    // Redirect FSM with registered valid/pc/flush outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= RESET_PC;
            flush_q       <= 1'b0;
            ds_pc_q       <= '0;
        end else begin
            flush_q <= 1'b0;
            if (ext_req) begin
                // Higher-priority source overrides anything, including an unaccepted
                // redirect or a pending delay slot; a same-cycle decode jump is dropped.
                state_q       <= StRedir;
                redir_valid_q <= 1'b1;
                redir_pc_q    <= ext_pc;
                flush_q       <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (fire && jump1D) begin
                            // Slot2 is the delay slot and runs; a jump there is ignored.
                            state_q       <= StRedir;
                            redir_valid_q <= 1'b1;
                            redir_pc_q    <= pc_jump1D;
                            flush_q       <= 1'b1;
                        end else if (fire && validD2 && jump2D) begin
                            state_q <= StWaitDs;
                            ds_pc_q <= pc_jump2D;
                        end
                    end
                    StWaitDs: begin
                        // The next issued slot1 is the delay slot; jumps in it are ignored.
                        if (fire) begin
                            state_q       <= StRedir;
                            redir_valid_q <= 1'b1;
                            redir_pc_q    <= ds_pc_q;
                            flush_q       <= 1'b1;
                        end
                    end
                    StRedir: begin
                        if (redir_ready) begin
                            state_q       <= StIdle;
                            redir_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q       <= StIdle;
                        redir_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // State-decoded kill/pending indications.
    always_comb begin
        kill_slot2D = (state_q == StWaitDs) & fire;
        killD       = (state_q == StRedir);
        ds_pending  = (state_q == StWaitDs);
    end

    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign flush_fetch = flush_q;

`ifdef REDIR_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Count redirects accepted by fetch; wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (redir_valid_q && redir_ready) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign redir_cnt = cnt_q;
`else
    assign redir_cnt = 32'd0;
`endif

endmodule
